// File: rtl/host_monitor.sv
// host_monitor: console byte FIFOs, finish/exit-code latch, retire watchdog and run-cycle
// counter snooped from the DCCM write port. Define HOST_MON_WDT_EN to build the watchdog.

module host_mon_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][7:0] mem_q;
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  ovf_q;
    logic                  pop, full, wr;

    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign ovf_o   = ovf_q;
    assign pop     = valid_o & ready_i;
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr      = push_i & (~full | pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({wr, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop)
                rptr_q <= rptr_q + 1'b1;
            if (push_i & ~wr)
                ovf_q <= 1'b1;
            cnt_q <= cnt_d;
        end
    end
endmodule

module host_monitor #(
    parameter int             XLEN         = 32,
    parameter int             NUM_CH       = 2,
    parameter int             FIFO_DEPTH   = 8,
    parameter logic [XLEN-1:0] CONSOLE_BASE = 'h0020_0000,
    parameter int             CH_STRIDE    = 4,
    parameter logic [XLEN-1:0] FINISH_ADDR  = 'h1000_0000,
    parameter int             WDT_LIMIT    = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dccm_wen,
    input  logic [XLEN-1:0]       dccm_waddr,
    input  logic [XLEN-1:0]       dccm_wdata,
    input  logic                  retire,
    output logic [NUM_CH-1:0]     ch_valid,
    output logic [8*NUM_CH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]     ch_ready,
    output logic [NUM_CH-1:0]     ch_ovf,
    output logic                  finish,
    output logic [XLEN-1:0]       exit_code,
    output logic                  timeout,
    output logic [31:0]           run_cycles
);
    logic            finish_q, timeout_q;
    logic [XLEN-1:0] exit_q;
    logic [31:0]     run_q, run_d;
    logic            done, fin_hit;

    assign done    = finish_q | timeout_q;
    assign fin_hit = dccm_wen & ~done & (dccm_waddr == FINISH_ADDR);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [XLEN-1:0] CH_ADDR = CONSOLE_BASE + XLEN'(i * CH_STRIDE);
        logic hit;
        assign hit = dccm_wen & ~done & (dccm_waddr == CH_ADDR);

        host_mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (hit),
            .wdata_i (dccm_wdata[7:0]),
            .ready_i (ch_ready[i]),
            .valid_o (ch_valid[i]),
            .data_o  (ch_data[8*i +: 8]),
            .ovf_o   (ch_ovf[i])
        );
    end

`ifdef HOST_MON_WDT_EN
    logic [31:0] wdt_cnt_q, wdt_cnt_d;
    logic        wdt_exp;

    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        if (retire)
            wdt_cnt_d = '0;
        else if (!done)
            wdt_cnt_d = wdt_cnt_q + 32'd1;
    end

    // A finish write on the expiry edge wins; done has a single cause.
    assign wdt_exp = ~done & ~retire & ~fin_hit & (wdt_cnt_q == 32'(WDT_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            if (wdt_exp)
                timeout_q <= 1'b1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign timeout_q     = 1'b0;
`endif

    always_comb begin
        run_d = run_q;
        if (!done && run_q != 32'hFFFF_FFFF)
            run_d = run_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_q <= 1'b0;
            exit_q   <= '0;
            run_q    <= '0;
        end else begin
            if (fin_hit) begin
                finish_q <= 1'b1;
                exit_q   <= dccm_wdata;
            end
            run_q <= run_d;
        end
    end

    assign finish     = finish_q;
    assign exit_code  = exit_q;
    assign timeout    = timeout_q;
    assign run_cycles = run_q;
endmodule

// File: tb/tb_host_monitor.sv
// Directed bench for host_monitor: console FIFOs, overflow, finish latch, watchdog, async reset.
`timescale 1ns/1ps
module tb_host_monitor;
    localparam logic [31:0] BASE = 32'h0020_0000;
    localparam logic [31:0] FIN  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dccm_wen = 1'b0;
    logic [31:0] dccm_waddr = '0;
    logic [31:0] dccm_wdata = '0;
    logic        retire = 1'b1;
    logic [1:0]  ch_valid;
    logic [15:0] ch_data;
    logic [1:0]  ch_ready = 2'b00;
    logic [1:0]  ch_ovf;
    logic        finish;
    logic [31:0] exit_code;
    logic        timeout;
    logic [31:0] run_cycles;

    int checks = 0;
    int failures = 0;

    host_monitor #(.XLEN(32), .NUM_CH(2), .FIFO_DEPTH(8), .CONSOLE_BASE(BASE),
                   .CH_STRIDE(4), .FINISH_ADDR(FIN), .WDT_LIMIT(10)) dut (
        .clk(clk), .rst_n(rst_n), .dccm_wen(dccm_wen), .dccm_waddr(dccm_waddr),
        .dccm_wdata(dccm_wdata), .retire(retire), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .ch_ovf(ch_ovf), .finish(finish), .exit_code(exit_code),
        .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cwrite(input logic [31:0] a, input logic [31:0] d);
        dccm_wen = 1'b1; dccm_waddr = a; dccm_wdata = d;
        tick();
        dccm_wen = 1'b0;
    endtask

    // Assert reset just after an edge, release after the next one; edges count from 1 afterwards.
    task automatic do_reset();
        rst_n = 1'b0; dccm_wen = 1'b0; ch_ready = 2'b00; retire = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tick();
        chk("rst_valid", 32'(ch_valid), 32'h0);
        chk("rst_data", 32'(ch_data), 32'h0);
        chk("rst_ovf", 32'(ch_ovf), 32'h0);
        chk("rst_finish", 32'(finish), 32'h0);
        chk("rst_exit", exit_code, 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_run", run_cycles, 32'h0);
        rst_n = 1'b1;

        // Streaming through channel 0 with the sink always ready
        ch_ready = 2'b01;
        cwrite(BASE, 32'h41);
        chk("s_v0", 32'(ch_valid), 32'h1); chk("s_d41", 32'(ch_data[7:0]), 32'h41);
        cwrite(BASE, 32'h42);
        chk("s_d42", 32'(ch_data[7:0]), 32'h42);
        cwrite(BASE, 32'h43);
        chk("s_d43", 32'(ch_data[7:0]), 32'h43); chk("s_ch1_idle", 32'(ch_valid[1]), 32'h0);
        tick();
        chk("s_empty", 32'(ch_valid), 32'h0);

        // Unmapped addresses never push
        cwrite(BASE + 32'd2, 32'h55);
        cwrite(BASE + 32'd8, 32'h56);
        chk("unmapped", 32'(ch_valid), 32'h0);

        // Overflow on channel 1
        ch_ready = 2'b00;
        for (int k = 0; k < 9; k++) cwrite(BASE + 32'd4, 32'h10 + 32'(k));
        chk("ovf_valid", 32'(ch_valid), 32'h2);
        chk("ovf_flag", 32'(ch_ovf), 32'h2);
        chk("ovf_head", 32'(ch_data[15:8]), 32'h10);
        tick();
        chk("ovf_hold", 32'(ch_data[15:8]), 32'h10);
        ch_ready = 2'b10;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_drain%0d", k), 32'(ch_data[15:8]), 32'h10 + 32'(k));
            tick();
        end
        chk("ovf_drained", 32'(ch_valid), 32'h0);
        chk("ovf_sticky", 32'(ch_ovf), 32'h2);

        // Full FIFO with simultaneous push and pop on channel 0
        ch_ready = 2'b00;
        for (int k = 0; k < 8; k++) cwrite(BASE, 32'h20 + 32'(k));
        chk("full_head", 32'(ch_data[7:0]), 32'h20);
        ch_ready = 2'b01;
        cwrite(BASE, 32'h99);
        chk("pp_noovf", 32'(ch_ovf[0]), 32'h0);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("pp_drain%0d", k), 32'(ch_data[7:0]), 32'h21 + 32'(k));
            tick();
        end
        chk("pp_last", 32'(ch_data[7:0]), 32'h99);
        chk("pp_last_v", 32'(ch_valid[0]), 32'h1);
        tick();
        chk("pp_empty", 32'(ch_valid), 32'h0);

        // Finish on edge 50 after reset release
        do_reset();
        for (int k = 0; k < 49; k++) tick();
        cwrite(FIN, 32'h0000_002A);
        chk("fin_flag", 32'(finish), 32'h1);
        chk("fin_exit", exit_code, 32'h2A);
        chk("fin_run", run_cycles, 32'd50);
        chk("fin_nto", 32'(timeout), 32'h0);
        cwrite(FIN, 32'h0000_0077);
        cwrite(BASE, 32'h61);
        tick();
        chk("fin_frozen", run_cycles, 32'd50);
        chk("fin_exit_keep", exit_code, 32'h2A);
        chk("fin_ignored", 32'(ch_valid), 32'h0);

`ifdef HOST_MON_WDT_EN
        // Timeout 11 edges after the last retire edge
        do_reset();
        tick(); tick();
        retire = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("wdt_pre%0d", k), 32'(timeout), 32'h0);
        end
        tick();
        chk("wdt_fire", 32'(timeout), 32'h1);
        cwrite(BASE, 32'h62);
        chk("wdt_ignored", 32'(ch_valid), 32'h0);
        chk("wdt_nofin", 32'(finish), 32'h0);

        // A retire on the 10th edge restarts the count
        do_reset();
        tick();
        retire = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        retire = 1'b1;
        tick();
        retire = 1'b0;
        tick();
        chk("wdt_rearm", 32'(timeout), 32'h0);
        for (int k = 0; k < 9; k++) tick();
        chk("wdt_rearm_late", 32'(timeout), 32'h0);

        // Finish coincides with the expiry edge
        do_reset();
        tick();
        retire = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        cwrite(FIN, 32'h7);
        chk("tie_fin", 32'(finish), 32'h1);
        chk("tie_nto", 32'(timeout), 32'h0);
        tick(); tick();
        chk("tie_nto_late", 32'(timeout), 32'h0);
        chk("tie_exit", exit_code, 32'h7);
`else
        do_reset();
        retire = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("nowdt_timeout", 32'(timeout), 32'h0);
        chk("nowdt_run", run_cycles, 32'd20);
`endif

        // Asynchronous reset mid-drain
        do_reset();
        for (int k = 0; k < 3; k++) cwrite(BASE, 32'h30 + 32'(k));
        cwrite(FIN, 32'h5);
        ch_ready = 2'b01;
        tick();
        chk("mid_v", 32'(ch_valid), 32'h1);
        chk("mid_fin", 32'(finish), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ch_valid), 32'h0);
        chk("arst_finish", 32'(finish), 32'h0);
        chk("arst_data", 32'(ch_data), 32'h0);
        chk("arst_run", run_cycles, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_after", 32'(ch_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/host_monitor.md
# host_monitor

Synthesizable replacement for the bench-level finish/console/watchdog logic. The block snoops the core's DCCM write port and decodes writes to NUM_CH console channel addresses, each feeding its own byte FIFO with a valid/ready drain. It also decodes the finish (tohost) address, which latches an exit code, and runs a retire watchdog and a run-cycle counter. It sits beside core_top and lets the same test-termination behaviour work on FPGA and in simulation.

## Interface
- XLEN, 32, address/data width
- NUM_CH, 2, console channels (1..8)
- FIFO_DEPTH, 8, entries per channel FIFO (power of two, ≥2)
- CONSOLE_BASE, 32'h0020_0000, address of channel 0
- CH_STRIDE, 4, byte distance between channel addresses
- FINISH_ADDR, 32'h1000_0000, finish/exit-code address
- WDT_LIMIT, 1000, max cycles without retirement
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- dccm_wen  in  1  DCCM write strobe
- dccm_waddr  in  XLEN  DCCM write address
- dccm_wdata  in  XLEN  DCCM write data
- retire  in  1  one or more instructions/stores retired this cycle
- ch_valid  out  NUM_CH  channel i has a byte
- ch_data  out  8*NUM_CH  byte for channel i in bits [8i+7:8i]
- ch_ready  in  NUM_CH  sink accepts channel i byte
- ch_ovf  out  NUM_CH  sticky: channel i dropped a byte
- finish  out  1  sticky: finish write seen
- exit_code  out  XLEN  dccm_wdata of the finish write
- timeout  out  1  sticky: watchdog expired
- run_cycles  out  32  cycles since reset release, frozen at done

## Operation
- Decode is active only while done = finish | timeout is 0. After done, all writes are ignored.
- Channel hit: dccm_wen & (dccm_waddr == CONSOLE_BASE + i*CH_STRIDE). An exact match is required. Unmapped addresses are ignored.
- Push: on a hit, dccm_wdata[7:0] enters FIFO i.
  - If FIFO i is full and not popping this cycle, the byte is dropped and ch_ovf[i] is set. Existing contents are unchanged.
- Pop: ch_valid[i] & ch_ready[i] removes the head. ch_data[i] holds steady while valid and not ready.
- Full FIFO with simultaneous push and pop: both occur; the count is unchanged and there is no overflow.
- Empty FIFO with push: no bypass; the byte is visible on the next cycle.
- Each FIFO uses a log2(FIFO_DEPTH)+1-bit count. Read/write pointers wrap modulo FIFO_DEPTH.
- Finish: dccm_wen & waddr == FINISH_ADDR sets finish and latches exit_code from the full XLEN dccm_wdata.
- Watchdog: the 32-bit wdt_cnt clears on retire and otherwise increments. On the edge where wdt_cnt == WDT_LIMIT & ~retire, timeout is set.
- Finish and timeout on the same edge: finish is set and timeout is not. done is single-winner.
- run_cycles increments every cycle while ~done and saturates at 32'hFFFF_FFFF.
- FIFOs continue to drain after done.
- rst_n assertion at any time, including mid-drain, immediately empties all FIFOs and clears all state.

## Timing
- Reset values: ch_valid=0, ch_data=0, ch_ovf=0, finish=0, exit_code=0, timeout=0, run_cycles=0; wdt_cnt=0.
- Console write at edge N → ch_valid[i]=1 after edge N (1-cycle latency).
- Finish write at edge N → finish/exit_code valid after edge N.
- With no retire after edge R, timeout rises after edge R+WDT_LIMIT+1.
- All outputs are registered. There is no combinational path from inputs to outputs, except ch_ready → none (ch_valid depends only on count).
- Sustained throughput: 1 byte/cycle per channel.

## Configuration
- HOST_MON_WDT_EN defined: the watchdog counter and timeout logic are present as described.
- HOST_MON_WDT_EN undefined: there is no wdt_cnt register, timeout is tied to 0, the retire input is unused, and done = finish.

## Test plan
- Reset, write 0x41,0x42,0x43 to CONSOLE_BASE with ch_ready[0]=1 → ch_data[7:0] shows 41,42,43 on consecutive cycles, each 1 cycle after its write. Channel 1 stays idle.
- NUM_CH=2, FIFO_DEPTH=8, ch_ready=0: 9 writes to CONSOLE_BASE+4 → ch_valid[1]=1, ch_ovf[1]=1. Draining then yields exactly the first 8 bytes in order.
- FIFO full, then push and pop on the same cycle → count stays 8, ch_ovf stays 0, and the new byte emerges last.
- Write 0x0000_002A to FINISH_ADDR at cycle 50 → finish=1, exit_code=0x2A, run_cycles frozen at 50. A later console write does not set ch_valid.
- HOST_MON_WDT_EN, WDT_LIMIT=10, retire pulses then stops → timeout rises exactly 11 cycles after the last retire edge. With a retire at cycle 10, timeout stays 0.
- Finish write on the same edge the watchdog expires → finish=1, timeout=0. Asserting rst_n mid-drain clears ch_valid and finish asynchronously.
